locked_cla_adder_pipe: RTL and testbench



---
 rtl/locked_cla_adder_pipe.sv | 177 +++++++++++++++++
 tb/tb_locked_cla_adder_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_cla_adder_pipe.sv
// Key-locked, two-stage pipelined carry-lookahead adder with serial key load and
// valid/ready handshakes. The sum is XOR-masked by a fold of (loaded key ^ golden key).
module locked_cla_adder_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned GROUP      = 4,
  parameter int unsigned KEY_WIDTH  = 64,
  parameter logic [63:0] KEY_GOLDEN = 64'hED06C024C5BF39E2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_start_i,
  input  logic             key_bit_i,
  input  logic             key_bit_valid_i,
  output logic             key_loaded_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
);

  localparam int unsigned NGroups = WIDTH / GROUP;
  localparam int unsigned CntW    = $clog2(KEY_WIDTH + 1);
  localparam logic [KEY_WIDTH-1:0] KeyGolden = KEY_WIDTH'(KEY_GOLDEN);

  typedef enum logic [1:0] {StNokey, StShift, StReady} state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_p_q, s1_g_q;
  logic [NGroups-1:0]   s1_gp_q, s1_gg_q;
  logic                 s1_cin_q;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH:0]       result_q, result_d;

  logic                 s1_load, s1_adv;
  logic [WIDTH-1:0]     p_d, g_d;
  logic [NGroups-1:0]   gp_d, gg_d;
  logic [WIDTH-1:0]     sum;
  logic                 carry_out;
  logic [KEY_WIDTH-1:0] diff;
  logic [WIDTH:0]       mask;

  // Stage 1 may move only into an empty or draining output register.
  assign s1_adv       = s1_valid_q && (!out_valid_q || out_ready_i);
  assign in_ready_o   = (state_q == StReady) && (!s1_valid_q || s1_adv);
  assign s1_load      = in_valid_i && in_ready_o;
  assign key_loaded_o = (state_q == StReady);
  assign out_valid_o  = out_valid_q;
  assign result_o     = result_q;

  // Key load FSM
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (state_q)
      StNokey: begin
        if (key_start_i) begin
          state_d = StShift;
          key_d   = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (key_start_i) begin
          key_d = '0;
          cnt_d = '0;
        end else if (key_bit_valid_i) begin
          key_d = {key_q[KEY_WIDTH-2:0], key_bit_i};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(KEY_WIDTH - 1)) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        // Reload only with an empty pipeline so in-flight results keep their key.
        if (key_start_i && !s1_valid_q && !out_valid_q) begin
          state_d = StShift;
          key_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StNokey;
    endcase
  end

  // Stage 1 propagate/generate, per bit and per group
  always_comb begin
    logic gpk;
    logic ggk;
    p_d = add1_i ^ add2_i;
    g_d = add1_i & add2_i;
    for (int k = 0; k < NGroups; k++) begin
      gpk = 1'b1;
      ggk = 1'b0;
      for (int b = 0; b < GROUP; b++) begin
        ggk = g_d[k*GROUP+b] | (p_d[k*GROUP+b] & ggk);
        gpk = gpk & p_d[k*GROUP+b];
      end
      gp_d[k] = gpk;
      gg_d[k] = ggk;
    end
  end

  // Stage 2: group lookahead feeds each group's carry-in; bits ripple inside a group.
  always_comb begin
    logic cg;
    logic c;
    sum = '0;
    cg  = s1_cin_q;
    for (int k = 0; k < NGroups; k++) begin
      c = cg;
      for (int b = 0; b < GROUP; b++) begin
        sum[k*GROUP+b] = s1_p_q[k*GROUP+b] ^ c;
        c = s1_g_q[k*GROUP+b] | (s1_p_q[k*GROUP+b] & c);
      end
      cg = s1_gg_q[k] | (s1_gp_q[k] & cg);
    end
    carry_out = cg;
  end

  assign diff = key_q ^ KeyGolden;

  always_comb begin
    mask = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      for (int j = i; j < KEY_WIDTH; j += WIDTH + 1) begin
        mask[i] = mask[i] ^ diff[j];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_load ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    out_valid_d = s1_adv ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
    result_d    = s1_adv ? ({carry_out, sum} ^ mask) : result_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StNokey;
      key_q       <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_gp_q     <= '0;
      s1_gg_q     <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      if (s1_load) begin
        s1_p_q   <= p_d;
        s1_g_q   <= g_d;
        s1_gp_q  <= gp_d;
        s1_gg_q  <= gg_d;
        s1_cin_q <= cin_i;
      end
    end
  end

endmodule

// File: tb/tb_locked_cla_adder_pipe.sv
// Scoreboard bench for locked_cla_adder_pipe: expected results are queued at input
// handshakes and compared at output handshakes; fixed vectors cover the unlock cases.
module tb_locked_cla_adder_pipe;

  localparam logic [63:0] Gold = 64'hED06C024C5BF39E2;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_start, key_bit, key_bit_valid;
  logic        in_valid, out_ready, cin;
  logic [31:0] a, b;
  logic        key_loaded, in_ready, out_valid;
  logic [32:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pop = 0;
  int          n0;
  logic [32:0] sb_q[$];
  logic [63:0] tb_key = '0;
  bit          toggle_en = 1'b0;
  int          ph = 0;
  logic [3:0]  pat = 4'b1001;
  logic        stall_prev = 1'b0;
  logic [32:0] held = '0;

  locked_cla_adder_pipe dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .key_start_i     (key_start),
    .key_bit_i       (key_bit),
    .key_bit_valid_i (key_bit_valid),
    .key_loaded_o    (key_loaded),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .add1_i          (a),
    .add2_i          (b),
    .cin_i           (cin),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .result_o        (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic [63:0] k);
    logic [32:0] s;
    logic [32:0] m;
    logic [63:0] d;
    s = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
    d = k ^ Gold;
    m = '0;
    for (int j = 0; j < 64; j++) m[j % 33] = m[j % 33] ^ d[j];
    return s ^ m;
  endfunction

  // Output-side scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (key_loaded)
        check("in_ready_occ", 64'(in_ready),
              ((sb_q.size() >= 2) && !out_ready) ? 64'd0 : 64'd1);
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(result), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) check("sb_empty_pop", 64'(out_valid), 64'd0);
        else check("result", 64'(result), 64'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, b, cin, tb_key));
      stall_prev = out_valid && !out_ready;
      held = result;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_en) begin
      out_ready = pat[ph % 4];
      ph++;
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        return;
      end
      step();
    end
    check("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic load_key(input logic [63:0] k);
    step();
    key_start = 1'b1;
    step();
    // Start together with a bit while shifting: the bit must be dropped.
    key_bit_valid = 1'b1;
    key_bit = 1'b1;
    step();
    key_start = 1'b0;
    key_bit_valid = 1'b0;
    check("kl_shift", 64'(key_loaded), 64'd0);
    for (int i = 63; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) step();
      key_bit = k[i];
      key_bit_valid = 1'b1;
      if (i == 0) begin
        @(negedge clk);
        check("kl_pre", 64'(key_loaded), 64'd0);
      end
      step();
      key_bit_valid = 1'b0;
    end
    check("kl_post", 64'(key_loaded), 64'd1);
    tb_key = k;
  endtask

  task automatic expect_one(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                            input logic [32:0] e);
    drain();
    send(ta, tb, tc);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    check("lat2", 64'(out_valid), 64'd1);
    check("fixed", 64'(result), 64'(e));
    step();
  endtask

  initial begin
    rst = 1'b1;
    key_start = 1'b0;
    key_bit = 1'b0;
    key_bit_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cin = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_loaded", 64'(key_loaded), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    #1 rst = 1'b0;

    load_key(Gold);
    expect_one(32'h29AF2430, 32'h7A1B9ABC, 1'b0, 33'h0A3CABEEC);
    load_key(Gold ^ 64'h2);
    expect_one(32'h29AF2430, 32'h7A1B9ABC, 1'b0, 33'h0A3CABEEE);
    load_key(Gold ^ 64'h1);
    expect_one(32'h29AF2430, 32'h7A1B9ABC, 1'b0, 33'h0A3CABEED);
    load_key(Gold);
    expect_one(32'h55555555, 32'hAAAAAAAA, 1'b1, 33'h100000000);
    load_key(Gold ^ (64'h1 << 34));
    expect_one(32'h55555555, 32'hAAAAAAAA, 1'b1, 33'h100000002);
    load_key(Gold ^ 64'h1 ^ (64'h1 << 33));
    expect_one(32'h55555555, 32'hAAAAAAAA, 1'b1, 33'h100000000);

    // Back-to-back stream under 1,0,0,1 backpressure
    load_key(Gold);
    n0 = n_pop;
    ph = 0;
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    toggle_en = 1'b0;
    drain();
    check("stream_count", 64'(n_pop - n0), 64'd16);

    // Reload request with a pending result is ignored
    out_ready = 1'b0;
    send(32'h12345678, 32'h0FEDCBA9, 1'b1);
    in_valid = 1'b0;
    step();
    step();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    check("ign_loaded", 64'(key_loaded), 64'd1);
    check("ign_valid", 64'(out_valid), 64'd1);
    drain();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    check("rl_loaded", 64'(key_loaded), 64'd0);
    check("rl_ready", 64'(in_ready), 64'd0);

    // Reset mid key-shift
    key_bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_bit = 1'($urandom_range(0, 1));
      step();
    end
    key_bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rks_loaded", 64'(key_loaded), 64'd0);
    check("rks_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rks_noaccept", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 1'b0;

    // Reset mid-stream with both stages full
    load_key(Gold);
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rms_valid", 64'(out_valid), 64'd0);
    check("rms_result", 64'(result), 64'd0);
    check("rms_loaded", 64'(key_loaded), 64'd0);
    check("rms_ready", 64'(in_ready), 64'd0);
    sb_q.delete();
    stall_prev = 1'b0;
    step();
    rst = 1'b0;
    load_key(Gold);
    expect_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
